// File: rtl/vga_capture.sv
// VGA stream sink: recovers pixel coordinates from h/v sync and video_enable,
// emits line/frame strobes, checks active geometry and tracks frame lock.
module vga_capture #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [1:0]  blue,
    input  logic        video_enable,
    input  logic        err_clear,
    output logic        pixel_valid,
    output logic [7:0]  pixel_data,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_start,
    output logic        line_end,
    output logic        frame_done,
    output logic        locked,
    output logic        line_len_err,
    output logic        line_count_err,
    output logic [15:0] frame_count
);
    localparam int unsigned CW   = 10;
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic [1:0] {SEEK, CAPTURE, VBLANK} state_t;

    logic          r_hs, r_vs, r_de, r_vs_d, r_de_d;
    logic [7:0]    r_rgb;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_x, r_y, w_x_nxt, w_y_nxt, w_y_chk, w_x_inc, w_y_inc;
    logic          r_bad, w_bad_nxt;
    logic          w_hs_act, w_vs_act, w_vs_act_d, w_vs_rise, w_vs_fall, w_de_fall;
    logic          w_valid, w_start, w_line_end, w_done, w_locked, w_len_err, w_cnt_err;
    logic [15:0]   w_fc;

    // Input registers plus a second copy for edge detection; sync idles inactive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs   <= SYNC_ACTIVE_LOW;
            r_vs   <= SYNC_ACTIVE_LOW;
            r_vs_d <= SYNC_ACTIVE_LOW;
            r_de   <= 1'b0;
            r_de_d <= 1'b0;
            r_rgb  <= 8'h00;
        end else begin
            r_hs   <= h_sync;
            r_vs   <= v_sync;
            r_vs_d <= r_vs;
            r_de   <= video_enable;
            r_de_d <= r_de;
            r_rgb  <= {red, green, blue};
        end
    end

    // *_act is 1 while the corresponding sync pulse is asserted
    assign w_hs_act   = r_hs ^ SYNC_ACTIVE_LOW;
    assign w_vs_act   = r_vs ^ SYNC_ACTIVE_LOW;
    assign w_vs_act_d = r_vs_d ^ SYNC_ACTIVE_LOW;
    assign w_vs_rise  = w_vs_act & ~w_vs_act_d;
    assign w_vs_fall  = ~w_vs_act & w_vs_act_d;
    assign w_de_fall  = ~r_de & r_de_d;
    assign w_x_inc    = (r_x == CMAX) ? r_x : r_x + CW'(1);
    assign w_y_inc    = (r_y == CMAX) ? r_y : r_y + CW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_y_chk     = r_y;
        w_bad_nxt   = r_bad;
        w_valid     = 1'b0;
        w_start     = 1'b0;
        w_line_end  = 1'b0;
        w_done      = 1'b0;
        w_locked    = locked;
        w_len_err   = line_len_err & ~err_clear;
        w_cnt_err   = line_count_err & ~err_clear;
        w_fc        = frame_count;
        case (r_state)
            CAPTURE: begin
                if (r_de) begin
                    w_valid = 1'b1;
                    w_start = (r_x == '0) && (r_y == '0);
                    w_x_nxt = w_x_inc;
                    if (w_hs_act) w_bad_nxt = 1'b1;
                end
                if (w_de_fall) begin
                    w_line_end = 1'b1;
                    if (r_x != CW'(H_ACTIVE)) begin
                        w_len_err = 1'b1;
                        w_bad_nxt = 1'b1;
                    end
                    w_x_nxt = '0;
                    w_y_nxt = w_y_inc;
                    w_y_chk = w_y_inc;
                end
                // The line-count check sees a line that ends in the same cycle
                if (w_vs_rise) begin
                    w_done = 1'b1;
                    if (w_y_chk != CW'(V_ACTIVE)) begin
                        w_cnt_err = 1'b1;
                        w_bad_nxt = 1'b1;
                    end
                    w_locked    = ~w_bad_nxt;
                    w_fc        = frame_count + 16'd1;
                    w_bad_nxt   = 1'b0;
                    w_state_nxt = VBLANK;
                end
            end
            default: begin
                if (w_vs_fall) begin
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_state_nxt = CAPTURE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= SEEK;
            r_x            <= '0;
            r_y            <= '0;
            r_bad          <= 1'b0;
            pixel_valid    <= 1'b0;
            pixel_data     <= 8'h00;
            pixel_x        <= '0;
            pixel_y        <= '0;
            frame_start    <= 1'b0;
            line_end       <= 1'b0;
            frame_done     <= 1'b0;
            locked         <= 1'b0;
            line_len_err   <= 1'b0;
            line_count_err <= 1'b0;
            frame_count    <= 16'h0000;
        end else begin
            r_state        <= w_state_nxt;
            r_x            <= w_x_nxt;
            r_y            <= w_y_nxt;
            r_bad          <= w_bad_nxt;
            pixel_valid    <= w_valid;
            frame_start    <= w_start;
            line_end       <= w_line_end;
            frame_done     <= w_done;
            locked         <= w_locked;
            line_len_err   <= w_len_err;
            line_count_err <= w_cnt_err;
            frame_count    <= w_fc;
            if (w_valid) begin
                pixel_data <= r_rgb;
                pixel_x    <= r_x;
                pixel_y    <= r_y;
            end
        end
    end
endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture with an 8x4 active area and low-active syncs.
module tb_vga_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic        h_sync, v_sync, video_enable, err_clear;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic        pixel_valid, frame_start, line_end, frame_done, locked;
    logic        line_len_err, line_count_err;
    logic [7:0]  pixel_data;
    logic [9:0]  pixel_x, pixel_y;
    logic [15:0] frame_count;

    typedef struct packed {
        logic [7:0]  d;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
        logic [31:0] cyc;
    } pix_t;

    typedef struct packed {
        logic        lk;
        logic [15:0] fc;
        logic        le;
        logic        ce;
    } fd_t;

    pix_t pix_q[$];
    logic le_q[$];
    fd_t  fd_q[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int n_pix = 0, n_fs = 0, n_le = 0, n_fd = 0;

    logic        exp_len_err = 1'b0;
    logic        exp_cnt_err = 1'b0;
    logic        exp_locked  = 1'b0;
    logic [15:0] exp_fc      = 16'h0000;

    vga_capture #(.H_ACTIVE(8), .V_ACTIVE(4), .SYNC_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync),
        .red(red), .green(green), .blue(blue), .video_enable(video_enable),
        .err_clear(err_clear), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
        .line_end(line_end), .frame_done(frame_done), .locked(locked),
        .line_len_err(line_len_err), .line_count_err(line_count_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        fails++;
        $display("FAIL %s: DUT strobe with no expected entry (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (pixel_valid) begin
                n_pix++;
                if (pix_q.size() == 0) unexpected("pixel_valid");
                else begin
                    pix_t e;
                    e = pix_q.pop_front();
                    chk("pixel_data", 32'(pixel_data), 32'(e.d));
                    chk("pixel_x", 32'(pixel_x), 32'(e.x));
                    chk("pixel_y", 32'(pixel_y), 32'(e.y));
                    chk("frame_start", 32'(frame_start), 32'(e.fs));
                    chk("pixel_latency_cycle", 32'(cyc), e.cyc);
                end
            end
            if (frame_start) n_fs++;
            if (line_end) begin
                n_le++;
                if (le_q.size() == 0) unexpected("line_end");
                else chk("line_len_err_at_line_end", 32'(line_len_err), 32'(le_q.pop_front()));
            end
            if (frame_done) begin
                n_fd++;
                if (fd_q.size() == 0) unexpected("frame_done");
                else begin
                    fd_t f;
                    f = fd_q.pop_front();
                    chk("locked_at_frame_done", 32'(locked), 32'(f.lk));
                    chk("frame_count_at_frame_done", 32'(frame_count), 32'(f.fc));
                    chk("line_len_err_at_frame_done", 32'(line_len_err), 32'(f.le));
                    chk("line_count_err_at_frame_done", 32'(line_count_err), 32'(f.ce));
                end
            end
        end
    end

    task automatic drive(input logic de, input logic hs, input logic vs, input logic [7:0] rgb,
                         input logic push, input logic [9:0] x, input logic [9:0] y);
        video_enable = de;
        h_sync = hs;
        v_sync = vs;
        {red, green, blue} = rgb;
        if (push && de)
            pix_q.push_back('{d: rgb, x: x, y: y, fs: (x == 10'd0 && y == 10'd0), cyc: 32'(cyc + 2)});
        @(negedge clk);
    endtask

    task automatic line(input int len, input logic push, input int y, input logic sp);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = (sp && i == 3 && y == 2) ? 8'hA5 : 8'(i * 16 + y);
            drive(1'b1, 1'b1, 1'b1, d, push, 10'(i), 10'(y));
        end
        if (push) begin
            if (len != 8) exp_len_err = 1'b1;
            le_q.push_back(exp_len_err);
        end
        for (int j = 0; j < 4; j++) drive(1'b0, !(j == 1 || j == 2), 1'b1, 8'h00, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic vs_pulse(input logic push, input logic good);
        if (push) begin
            exp_fc = exp_fc + 16'd1;
            exp_locked = good;
            fd_q.push_back('{lk: good, fc: exp_fc, le: exp_len_err, ce: exp_cnt_err});
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 10'd0, 10'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic frame(input string name, input int nlines, input int short_line, input logic sp);
        logic good;
        int len, tot, p0, f0, l0, d0;
        good = (nlines == 4);
        tot = 0;
        p0 = n_pix; f0 = n_fs; l0 = n_le; d0 = n_fd;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_line) ? 7 : 8;
            if (len != 8) good = 1'b0;
            tot += len;
            line(len, 1'b1, l, sp);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 10'd0, 10'd0);
        if (nlines != 4) exp_cnt_err = 1'b1;
        vs_pulse(1'b1, good);
        chk({name, "_pixel_count"}, 32'(n_pix - p0), 32'(tot));
        chk({name, "_frame_start_count"}, 32'(n_fs - f0), 32'd1);
        chk({name, "_line_end_count"}, 32'(n_le - l0), 32'(nlines));
        chk({name, "_frame_done_count"}, 32'(n_fd - d0), 32'd1);
        chk({name, "_locked"}, 32'(locked), 32'(exp_locked));
        chk({name, "_frame_count"}, 32'(frame_count), 32'(exp_fc));
        chk({name, "_line_len_err"}, 32'(line_len_err), 32'(exp_len_err));
        chk({name, "_line_count_err"}, 32'(line_count_err), 32'(exp_cnt_err));
    endtask

    task automatic check_zero(input string name);
        chk({name, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
        chk({name, "_pixel_data"}, 32'(pixel_data), 32'd0);
        chk({name, "_pixel_xy"}, 32'({pixel_x, pixel_y}), 32'd0);
        chk({name, "_strobes"}, 32'({frame_start, line_end, frame_done}), 32'd0);
        chk({name, "_locked"}, 32'(locked), 32'd0);
        chk({name, "_errs"}, 32'({line_len_err, line_count_err}), 32'd0);
        chk({name, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, l0;
        rst = 1'b1;
        h_sync = 1'b1; v_sync = 1'b1; video_enable = 1'b0; err_clear = 1'b0;
        {red, green, blue} = 8'h00;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // No v_sync yet: enable toggling must be ignored
        p0 = n_pix; l0 = n_le;
        for (int l = 0; l < 3; l++) line(8, 1'b0, l, 1'b0);
        chk("seek_no_pixels", 32'(n_pix - p0), 32'd0);
        chk("seek_no_line_end", 32'(n_le - l0), 32'd0);
        vs_pulse(1'b0, 1'b0);

        frame("clean", 4, -1, 1'b0);
        frame("pixel_a5", 4, -1, 1'b1);
        frame("short_line", 4, 1, 1'b0);

        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        exp_len_err = 1'b0;
        @(negedge clk);
        chk("err_clear_line_len_err", 32'(line_len_err), 32'd0);

        frame("three_lines", 3, -1, 1'b0);
        frame("relock", 4, -1, 1'b0);

        // Asynchronous reset in the middle of a line
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 8'(i * 16), 1'b1, 10'(i), 10'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero("async_reset");
        pix_q.delete();
        le_q.delete();
        fd_q.delete();
        exp_len_err = 1'b0; exp_cnt_err = 1'b0; exp_locked = 1'b0; exp_fc = 16'h0000;
        video_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        p0 = n_pix; l0 = n_le;
        line(8, 1'b0, 0, 1'b0);
        chk("post_reset_no_pixels", 32'(n_pix - p0), 32'd0);
        chk("post_reset_no_line_end", 32'(n_le - l0), 32'd0);
        vs_pulse(1'b0, 1'b0);
        frame("post_reset", 4, -1, 1'b0);

        repeat (10) drive(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 10'd0, 10'd0);
        chk("pix_q_drained", 32'(pix_q.size()), 32'd0);
        chk("le_q_drained", 32'(le_q.size()), 32'd0);
        chk("fd_q_drained", 32'(fd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
